execute_stage: RTL and testbench

Parametrised execute stage for the 5-stage RISC-V pipeline, sitting between the ID/EX and EX/MEM pipeline registers. It adds operand forwarding muxes, full RV32I ALU and branch-condition coverage, and JALR target generation. It includes an iterative multi-cycle multiplier for MUL/MULH/MULHU that stalls upstream while busy. It owns the EX/MEM register, with stall-bubble and flush behaviour.

---
 rtl/exec_pkg.sv | 48 ++++
 rtl/mul_iter.sv | 93 +++++++++
 rtl/execute_stage.sv | 170 +++++++++++++++++
 tb/tb_execute_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU op encoding, branch funct3 codes,
// forwarding selects and the multiplier state machine encoding.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULH  = 4'd11,
    ALU_MULHU = 4'd12,
    ALU_PASSB = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle on operand
// magnitudes, sign restored in DONE for signed x signed requests.
module mul_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic              flush,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  mul_state_e        state_r, state_nxt_s;
  logic [CW-1:0]     count_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   mcand_r;
  logic              neg_r;
  logic [XLEN:0]     step_sum_s;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Upper half accumulates the multiplicand when the multiplier LSB is set
  assign step_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; flush aborts a running multiply
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = BUSY;
        else       state_nxt_s = IDLE;
      end
      BUSY: begin
        if (flush)                 state_nxt_s = IDLE;
        else if (count_r == ONE_C) state_nxt_s = DONE;
        else                       state_nxt_s = BUSY;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture on accept, then one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
      acc_r   <= {(2*XLEN){1'b0}};
      mcand_r <= {XLEN{1'b0}};
      neg_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r <= is_signed ? abs_val(op_a) : op_a;
            acc_r   <= {{XLEN{1'b0}}, (is_signed ? abs_val(op_b) : op_b)};
            neg_r   <= is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            count_r <= CW'(XLEN);
          end
        end
        BUSY: begin
          if (!flush) begin
            acc_r   <= {step_sum_s, acc_r[XLEN-1:1]};
            count_r <= count_r - ONE_C;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = ((state_r == IDLE) & start) | (state_r == BUSY);
  assign done    = (state_r == DONE);
  assign product = neg_r ? (~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_r;

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution, jump
// targets, iterative multiplier and the EX/MEM pipeline register.
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [REGW-1:0] RdE,
  input  logic            ValidE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      BranchTypeE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [REGW-1:0] RdM,
  output logic [1:0]      ResultSrcM,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE,
  output logic            BusyE
);
  localparam int SHW = $clog2(XLEN);

  alu_op_e           op_s;
  logic [XLEN-1:0]   src_a_s, src_b_s, write_data_s, alu_s, jalr_sum_s;
  logic [SHW-1:0]    shamt_s;
  logic [2*XLEN-1:0] mul_prod_s;
  logic              mul_req_s, mul_busy_s, mul_done_s, br_taken_s, bubble_s;

  assign op_s    = alu_op_e'(ALUControlE);
  assign shamt_s = src_b_s[SHW-1:0];

  // Forwarding muxes; the reserved select falls back to the register value
  always_comb begin
    src_a_s      = RD1E;
    write_data_s = RD2E;
    case (fwd_sel_e'(ForwardAE))
      FWD_WB:  src_a_s = ResultW;
      FWD_MEM: src_a_s = ALUResultM;
      default: src_a_s = RD1E;
    endcase
    case (fwd_sel_e'(ForwardBE))
      FWD_WB:  write_data_s = ResultW;
      FWD_MEM: write_data_s = ALUResultM;
      default: write_data_s = RD2E;
    endcase
  end

  assign src_b_s = ALUSrcE ? ImmExtE : write_data_s;

  // ALU; multiply ops only return the product in the DONE cycle
  always_comb begin
    alu_s = {XLEN{1'b0}};
    case (op_s)
      ALU_ADD:   alu_s = src_a_s + src_b_s;
      ALU_SUB:   alu_s = src_a_s - src_b_s;
      ALU_AND:   alu_s = src_a_s & src_b_s;
      ALU_OR:    alu_s = src_a_s | src_b_s;
      ALU_XOR:   alu_s = src_a_s ^ src_b_s;
      ALU_SLT:   alu_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
      ALU_SLTU:  alu_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
      ALU_SLL:   alu_s = src_a_s << shamt_s;
      ALU_SRL:   alu_s = src_a_s >> shamt_s;
      ALU_SRA:   alu_s = $signed(src_a_s) >>> shamt_s;
      ALU_MUL:   alu_s = mul_done_s ? mul_prod_s[XLEN-1:0] : {XLEN{1'b0}};
      ALU_MULH,
      ALU_MULHU: alu_s = mul_done_s ? mul_prod_s[2*XLEN-1:XLEN] : {XLEN{1'b0}};
      ALU_PASSB: alu_s = src_b_s;
      default:   alu_s = {XLEN{1'b0}};
    endcase
  end

  // Branch comparator
  always_comb begin
    br_taken_s = 1'b0;
    case (BranchTypeE)
      BR_EQ:   br_taken_s = (src_a_s == src_b_s);
      BR_NE:   br_taken_s = (src_a_s != src_b_s);
      BR_LT:   br_taken_s = ($signed(src_a_s) <  $signed(src_b_s));
      BR_GE:   br_taken_s = ($signed(src_a_s) >= $signed(src_b_s));
      BR_LTU:  br_taken_s = (src_a_s <  src_b_s);
      BR_GEU:  br_taken_s = (src_a_s >= src_b_s);
      default: br_taken_s = 1'b0;
    endcase
  end

  assign jalr_sum_s = src_a_s + ImmExtE;
  assign PCTargetE  = JalrE ? {jalr_sum_s[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
  assign PCSrcE     = ValidE & ~FlushE & (JumpE | (BranchE & br_taken_s));
  assign mul_req_s  = ValidE & ~FlushE & is_mul_op(op_s);

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_req_s),
        .is_signed (op_s == ALU_MULH),
        .flush     (FlushE),
        .op_a      (src_a_s),
        .op_b      (src_b_s),
        .busy      (mul_busy_s),
        .done      (mul_done_s),
        .product   (mul_prod_s)
      );
    end else begin : g_no_mul
      assign mul_busy_s = 1'b0;
      assign mul_done_s = 1'b0;
      assign mul_prod_s = {(2*XLEN){1'b0}};
    end
  endgenerate

  assign BusyE    = mul_busy_s;
  assign bubble_s = FlushE | BusyE | ~ValidE;

  // EX/MEM register; bubbles clear every field so the contents stay deterministic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= {XLEN{1'b0}};
      WriteDataM <= {XLEN{1'b0}};
      PCPlus4M   <= {XLEN{1'b0}};
      RdM        <= {REGW{1'b0}};
      ResultSrcM <= 2'b00;
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
    end else if (bubble_s) begin
      ALUResultM <= {XLEN{1'b0}};
      WriteDataM <= {XLEN{1'b0}};
      PCPlus4M   <= {XLEN{1'b0}};
      RdM        <= {REGW{1'b0}};
      ResultSrcM <= 2'b00;
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
    end else begin
      ALUResultM <= alu_s;
      WriteDataM <= write_data_s;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      ResultSrcM <= ResultSrcE;
      ValidM     <= 1'b1;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: table of single-cycle ALU vectors plus
// hand-written branch, jump, multiply, flush and reset sequences.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, FlushE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [2:0]  BranchTypeE;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic        ValidM, RegWriteM, MemWriteM, PCSrcE, BusyE;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] resw, exp_alu, exp_wd;
  } vec_t;

  typedef struct {
    logic [2:0] bt;
    logic       taken;
  } br_t;

  vec_t vecs[15];
  br_t  brs[7];

  execute_stage #(.XLEN(32), .REGW(5), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .FlushE(FlushE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .ResultSrcM(ResultSrcM), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    RD1E = 32'd0; RD2E = 32'd0; ImmExtE = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0;
    ResultW = 32'd0; RdE = 5'd0; ValidE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
    JumpE = 1'b0; JalrE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0; FlushE = 1'b0;
    ResultSrcE = 2'b00; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUControlE = 4'd0; BranchTypeE = 3'b000;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic src, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [31:0] resw,
                              input logic [31:0] exp_alu, input logic [31:0] exp_wd);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.src = src; v.fa = fa; v.fb = fb;
    v.resw = resw; v.exp_alu = exp_alu; v.exp_wd = exp_wd;
    return v;
  endfunction

  // Issue one multiply and follow it through accept, BUSY and DONE
  task automatic do_mul(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int busy_cycles;
    bit vm_bad;
    bit timed_out;
    busy_cycles = 0; vm_bad = 1'b0; timed_out = 1'b1;
    @(negedge clk);
    idle_inputs();
    ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = op; RD1E = a; RD2E = b;
    RdE = 5'd7; PCPlus4E = 32'h0000_0304;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!BusyE) begin
        timed_out = 1'b0;
        break;
      end
      busy_cycles++;
      @(posedge clk); #1;
      if (ValidM !== 1'b0) vm_bad = 1'b1;
      @(negedge clk);
    end
    check1({name, "_timeout"}, timed_out, 1'b0);
    check32({name, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
    check1({name, "_bubble_while_busy"}, vm_bad, 1'b0);
    @(posedge clk); #1;
    check32({name, "_result"}, ALUResultM, exp);
    check1({name, "_validm"}, ValidM, 1'b1);
    check32({name, "_rdm"}, {27'd0, RdM}, 32'd7);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check1({name, "_single_commit"}, ValidM, 1'b0);
  endtask

  initial begin
    bit stray;
    vecs[0]  = mk(4'd0,  32'd3,         32'd4,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'd7,         32'd4);
    vecs[1]  = mk(4'd0,  32'd5,         32'd0,         32'd3,    1'b1, 2'd2, 2'd0, 32'd0,         32'd10,        32'd0);
    vecs[2]  = mk(4'd1,  32'd5,         32'd8,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'hFFFF_FFFD, 32'd8);
    vecs[3]  = mk(4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'h00F0_1200, 32'h0FF0_FF00);
    vecs[4]  = mk(4'd3,  32'hF000_0001, 32'h0000_0F10, 32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'hF000_0F11, 32'h0000_0F10);
    vecs[5]  = mk(4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'hF0F0_0F0F, 32'h0F0F_0F0F);
    vecs[6]  = mk(4'd5,  32'hFFFF_FFFF, 32'd1,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'd1,         32'd1);
    vecs[7]  = mk(4'd6,  32'hFFFF_FFFF, 32'd1,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'd0,         32'd1);
    vecs[8]  = mk(4'd7,  32'd1,         32'd0,         32'h23,   1'b1, 2'd0, 2'd0, 32'd0,         32'd8,         32'd0);
    vecs[9]  = mk(4'd8,  32'h8000_0000, 32'd4,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'h0800_0000, 32'd4);
    vecs[10] = mk(4'd9,  32'h8000_0000, 32'd4,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'hF800_0000, 32'd4);
    vecs[11] = mk(4'd13, 32'd0,         32'h1234_5678, 32'd0,    1'b0, 2'd0, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE);
    vecs[12] = mk(4'd14, 32'd5,         32'd6,         32'd0,    1'b0, 2'd0, 2'd0, 32'd0,         32'd0,         32'd6);
    vecs[13] = mk(4'd0,  32'd10,        32'd20,        32'd0,    1'b0, 2'd3, 2'd0, 32'd0,         32'd30,        32'd20);
    vecs[14] = mk(4'd0,  32'd1,         32'h55,        32'd0,    1'b0, 2'd0, 2'd2, 32'd0,         32'd31,        32'd30);

    brs[0] = '{3'b100, 1'b1};
    brs[1] = '{3'b110, 1'b0};
    brs[2] = '{3'b101, 1'b0};
    brs[3] = '{3'b111, 1'b1};
    brs[4] = '{3'b000, 1'b0};
    brs[5] = '{3'b001, 1'b1};
    brs[6] = '{3'b010, 1'b0};

    reset = 1'b0;
    idle_inputs();
    #1;
    check32("reset_aluresultm", ALUResultM, 32'd0);
    check32("reset_writedatam", WriteDataM, 32'd0);
    check32("reset_pcplus4m", PCPlus4M, 32'd0);
    check32("reset_rdm", {27'd0, RdM}, 32'd0);
    check1("reset_validm", ValidM, 1'b0);
    check1("reset_regwritem", RegWriteM, 1'b0);
    check1("reset_busy", BusyE, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back single-cycle ops; some rows forward the previous row's result
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      idle_inputs();
      ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = vecs[i].op;
      RD1E = vecs[i].rd1; RD2E = vecs[i].rd2; ImmExtE = vecs[i].imm; ALUSrcE = vecs[i].src;
      ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb; ResultW = vecs[i].resw;
      RdE = 5'(i + 1); ResultSrcE = 2'(i);
      @(posedge clk); #1;
      check32($sformatf("vec%0d_alu", i), ALUResultM, vecs[i].exp_alu);
      check32($sformatf("vec%0d_wd", i), WriteDataM, vecs[i].exp_wd);
      check1($sformatf("vec%0d_validm", i), ValidM, 1'b1);
      check32($sformatf("vec%0d_rdm", i), {27'd0, RdM}, 32'(i + 1));
      check32($sformatf("vec%0d_rsrcm", i), {30'd0, ResultSrcM}, 32'(i % 4));
    end

    @(negedge clk);
    idle_inputs();
    RD1E = 32'd9; RD2E = 32'd9;
    @(posedge clk); #1;
    check1("invalid_bubble_validm", ValidM, 1'b0);
    check32("invalid_bubble_alu", ALUResultM, 32'd0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle_inputs();
      ValidE = 1'b1; BranchE = 1'b1; BranchTypeE = brs[i].bt; ALUControlE = 4'd1;
      RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; PCE = 32'h0000_0100; ImmExtE = 32'h0000_0040;
      #1;
      check1($sformatf("branch_%b_pcsrc", brs[i].bt), PCSrcE, brs[i].taken);
      check32($sformatf("branch_%b_target", brs[i].bt), PCTargetE, 32'h0000_0140);
    end
    BranchE = 1'b0; BranchTypeE = 3'b100;
    #1;
    check1("branch_not_branch_pcsrc", PCSrcE, 1'b0);
    BranchE = 1'b1; FlushE = 1'b1;
    #1;
    check1("branch_flushed_pcsrc", PCSrcE, 1'b0);
    @(posedge clk); #1;
    check1("branch_flushed_validm", ValidM, 1'b0);

    @(negedge clk);
    idle_inputs();
    ValidE = 1'b1; RegWriteE = 1'b1; JumpE = 1'b1; JalrE = 1'b1; ResultSrcE = 2'b10;
    RD1E = 32'h0000_1003; ImmExtE = 32'd4; PCE = 32'h0000_0204; PCPlus4E = 32'h0000_0208; RdE = 5'd1;
    #1;
    check32("jalr_target", PCTargetE, 32'h0000_1006);
    check1("jalr_pcsrc", PCSrcE, 1'b1);
    @(posedge clk); #1;
    check32("jalr_pcplus4m", PCPlus4M, 32'h0000_0208);
    check1("jalr_validm", ValidM, 1'b1);

    do_mul("mulh", 4'd11, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
    do_mul("mul", 4'd10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    do_mul("mulhu", 4'd12, 32'hFFFF_FFFF, 32'd2, 32'd1);
    do_mul("mulh_minint", 4'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

    // Flush in the tenth BUSY cycle, then an ADD must go straight through
    @(negedge clk);
    idle_inputs();
    ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = 4'd11; RD1E = 32'hFFFF_FFFD; RD2E = 32'd7;
    #1;
    check1("flush_accept_busy", BusyE, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    check1("flush_busy_before", BusyE, 1'b1);
    FlushE = 1'b1;
    @(posedge clk); #1;
    check1("flush_validm", ValidM, 1'b0);
    @(negedge clk);
    idle_inputs();
    ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = 4'd0; RD1E = 32'd100; RD2E = 32'd23; RdE = 5'd9;
    #1;
    check1("flush_idle_busy", BusyE, 1'b0);
    @(posedge clk); #1;
    check32("flush_add_result", ALUResultM, 32'd123);
    check1("flush_add_validm", ValidM, 1'b1);

    #2 reset = 1'b0;
    #1;
    check32("async_reset_alu", ALUResultM, 32'd0);
    check1("async_reset_validm", ValidM, 1'b0);
    check1("async_reset_regwritem", RegWriteM, 1'b0);
    check32("async_reset_rdm", {27'd0, RdM}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    stray = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (ValidM !== 1'b0 || BusyE !== 1'b0) stray = 1'b1;
    end
    check1("flush_no_late_commit", stray, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    idle_inputs();
    ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = 4'd11; RD1E = 32'd3; RD2E = 32'd3;
    repeat (5) @(negedge clk);
    ValidE = 1'b0;
    #1;
    check1("midmul_busy_before_reset", BusyE, 1'b1);
    #1 reset = 1'b0;
    #1;
    check1("midmul_reset_busy", BusyE, 1'b0);
    check1("midmul_reset_validm", ValidM, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ValidM !== 1'b0 || BusyE !== 1'b0) stray = 1'b1;
    end
    check1("midmul_no_commit_after_release", stray, 1'b0);
    do_mul("mul_after_reset", 4'd10, 32'd6, 32'd7, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
